// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR tap sequencer.
// No logic here; the sequencer and its delay line import these defaults.
package fir_pkg;
  localparam int FIR_NUM_TAPS = 16;
  localparam int FIR_DATA_W   = 16;
  localparam int FIR_TAP_W    = $clog2(FIR_NUM_TAPS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;
endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history: one write per accept, combinational read at rd_idx.
// Write lands on the clock edge; flush clears every entry and the pointer in one cycle.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int N = FIR_NUM_TAPS,
  parameter int W = FIR_DATA_W
) (
  input  logic                    CLK,
  input  logic                    ARST,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic signed [W-1:0]     wr_data,
  input  logic [$clog2(N)-1:0]    rd_idx,
  output logic signed [W-1:0]     rd_data,
  output logic [$clog2(N)-1:0]    wr_ptr
);
  localparam int AW = $clog2(N);

  logic signed [W-1:0] mem_q [N];
  logic signed [W-1:0] mem_d [N];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      for (int i = 0; i < N; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
    end else if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      // N is a power of two, so the pointer wraps naturally.
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign wr_ptr  = wr_ptr_q;
endmodule

// File: rtl/fir_tap_sequencer.sv
// Turns each accepted sample into NUM_TAPS registered (x[n-k], h[k]) MAC operand cycles.
// Tap 0 appears the cycle after accept; in_ready stays low for the whole burst.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int DATA_W   = FIR_DATA_W
) (
  input  logic                        CLK,
  input  logic                        ARST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic signed [DATA_W-1:0]    coef_wdata,
  output logic                        coef_drop,
  input  logic                        flush,
  output logic                        mac_initialize,
  output logic                        mac_input_valid,
  output logic signed [DATA_W-1:0]    mac_in_data,
  output logic signed [DATA_W-1:0]    mac_coef,
  output logic                        busy
);
  localparam int            TW     = $clog2(NUM_TAPS);
  localparam logic [TW-1:0] LAST_K = TW'(NUM_TAPS - 1);

  state_t                     state_q, state_d;
  logic [TW-1:0]              k_q, k_d;
  logic signed [DATA_W-1:0]   coef_q [NUM_TAPS];
  logic signed [DATA_W-1:0]   coef_d [NUM_TAPS];
  logic                       mac_initialize_q, mac_initialize_d;
  logic                       mac_input_valid_q, mac_input_valid_d;
  logic signed [DATA_W-1:0]   mac_in_data_q, mac_in_data_d;
  logic signed [DATA_W-1:0]   mac_coef_q, mac_coef_d;
  logic                       coef_drop_q, coef_drop_d;

  logic                       accept;
  logic                       dl_flush;
  logic [TW-1:0]              k_nxt;
  logic [TW-1:0]              wr_ptr;
  logic [TW-1:0]              rd_idx;
  logic signed [DATA_W-1:0]   rd_data;

  assign in_ready = (state_q == ST_IDLE) && !flush;
  assign accept   = in_ready && in_valid;
  assign dl_flush = (state_q == ST_IDLE) && flush;
  assign k_nxt    = k_q + TW'(1);
  // wr_ptr already points past the newest sample once a burst is running.
  assign rd_idx   = wr_ptr - TW'(1) - k_nxt;

  fir_delay_line #(
    .N (NUM_TAPS),
    .W (DATA_W)
  ) u_delay_line (
    .CLK     (CLK),
    .ARST    (ARST),
    .flush   (dl_flush),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr)
  );

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    coef_d            = coef_q;
    mac_initialize_d  = 1'b0;
    mac_input_valid_d = 1'b0;
    mac_in_data_d     = '0;
    mac_coef_d        = '0;
    coef_drop_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coef_we) coef_d[coef_addr] = coef_wdata;
        if (accept) begin
          // Tap 0 bypasses both arrays so a same-cycle sample and coefficient are used.
          state_d           = ST_BURST;
          k_d               = '0;
          mac_initialize_d  = 1'b1;
          mac_input_valid_d = 1'b1;
          mac_in_data_d     = in_data;
          mac_coef_d        = coef_d[0];
        end
      end
      ST_BURST: begin
        coef_drop_d = coef_we;
        if (k_q != LAST_K) begin
          k_d               = k_nxt;
          mac_input_valid_d = 1'b1;
          mac_in_data_d     = rd_data;
          mac_coef_d        = coef_q[k_nxt];
        end else begin
          state_d = ST_IDLE;
          k_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q           <= ST_IDLE;
      k_q               <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
      mac_initialize_q  <= 1'b0;
      mac_input_valid_q <= 1'b0;
      mac_in_data_q     <= '0;
      mac_coef_q        <= '0;
      coef_drop_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      coef_q            <= coef_d;
      mac_initialize_q  <= mac_initialize_d;
      mac_input_valid_q <= mac_input_valid_d;
      mac_in_data_q     <= mac_in_data_d;
      mac_coef_q        <= mac_coef_d;
      coef_drop_q       <= coef_drop_d;
    end
  end

  assign mac_initialize  = mac_initialize_q;
  assign mac_input_valid = mac_input_valid_q;
  assign mac_in_data     = mac_in_data_q;
  assign mac_coef        = mac_coef_q;
  assign coef_drop       = coef_drop_q;
  assign busy            = (state_q == ST_BURST);
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: queue-based reference model compared every cycle,
// directed impulse/wrap/drop/flush/reset scenarios, then randomized traffic.
module tb_fir_tap_sequencer;
  localparam int N = 16;
  localparam int W = 16;

  logic                CLK = 1'b0;
  logic                ARST = 1'b1;
  logic                in_valid = 1'b0;
  logic                coef_we = 1'b0;
  logic                flush = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic signed [W-1:0] coef_wdata = '0;
  logic [3:0]          coef_addr = '0;
  logic                in_ready, coef_drop, mac_initialize, mac_input_valid, busy;
  logic signed [W-1:0] mac_in_data, mac_coef;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  fir_tap_sequencer #(.NUM_TAPS(N), .DATA_W(W)) dut (
    .CLK             (CLK),
    .ARST            (ARST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_wdata      (coef_wdata),
    .coef_drop       (coef_drop),
    .flush           (flush),
    .mac_initialize  (mac_initialize),
    .mac_input_valid (mac_input_valid),
    .mac_in_data     (mac_in_data),
    .mac_coef        (mac_coef),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history as a newest-first list, a burst as a list of pending taps.
  int   hist[$];
  int   h[N];
  int   qd[$];
  int   qc[$];
  logic m_vld = 1'b0;
  logic m_init = 1'b0;
  logic m_drop = 1'b0;
  int   m_data = 0;
  int   m_coef = 0;

  always @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      hist.delete(); qd.delete(); qc.delete();
      foreach (h[i]) h[i] = 0;
      m_vld = 0; m_init = 0; m_drop = 0; m_data = 0; m_coef = 0;
    end else begin
      m_init = 0;
      m_drop = m_vld && coef_we;
      if (m_vld) begin
        if (qd.size() > 0) begin
          m_data = qd.pop_front();
          m_coef = qc.pop_front();
        end else begin
          m_vld = 0; m_data = 0; m_coef = 0;
        end
      end else begin
        m_data = 0; m_coef = 0;
        if (coef_we) h[coef_addr] = coef_wdata;
        if (flush) hist.delete();
        else if (in_valid) begin
          hist.push_front(in_data);
          if (hist.size() > N) void'(hist.pop_back());
          for (int k = 0; k < N; k++) begin
            qd.push_back(k < hist.size() ? hist[k] : 0);
            qc.push_back(h[k]);
          end
          m_vld = 1; m_init = 1;
          m_data = qd.pop_front();
          m_coef = qc.pop_front();
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("init",  mac_initialize, m_init);
    chk("vld",   mac_input_valid, m_vld);
    chk("data",  mac_in_data, m_data);
    chk("coef",  mac_coef, m_coef);
    chk("drop",  coef_drop, m_drop);
    chk("busy",  busy, m_vld);
    chk("ready", in_ready, !m_vld && !flush);
  end

  int td[N];
  int tc[N];
  int sum;

  task automatic wait_ready();
    int cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
    end
    chk("ready_wait", in_ready, 1);
  endtask

  // Accepts one sample and captures the full tap burst, checking its timing.
  task automatic burst(input int d);
    int ninit = 0;
    wait_ready();
    in_valid = 1'b1; in_data = 16'(d);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      td[k] = mac_in_data;
      tc[k] = mac_coef;
      ninit += int'(mac_initialize);
      chk("tap_vld", mac_input_valid, 1);
      chk("tap_busy_ready", in_ready, 0);
      if (k == 0) chk("tap0_init", mac_initialize, 1);
      @(posedge CLK); #1;
    end
    chk("end_ready", in_ready, 1);
    chk("end_vld", mac_input_valid, 0);
    chk("init_once", ninit, 1);
  endtask

  initial begin
    #1;
    chk("rst_vld", mac_input_valid, 0);
    chk("rst_data", mac_in_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", coef_drop, 0);
    #20 ARST = 1'b0;
    @(posedge CLK); #1;

    // Impulse response with h[k] = k+1.
    for (int k = 0; k < N; k++) begin
      coef_we = 1'b1; coef_addr = 4'(k); coef_wdata = 16'(k + 1);
      @(posedge CLK); #1;
    end
    coef_we = 1'b0;
    for (int j = 0; j < N; j++) begin
      burst(j == 0 ? 1 : 0);
      sum = 0;
      for (int k = 0; k < N; k++) sum += td[k] * tc[k];
      chk("impulse_out", sum, j + 1);
      chk("impulse_pos", td[j], 1);
    end

    // Wrap: samples 1..21, last burst carries 21 down to 6.
    for (int s = 1; s <= 21; s++) burst(s);
    for (int k = 0; k < N; k++) chk("wrap_tap", td[k], 21 - k);

    // Coefficient write mid-burst is dropped.
    wait_ready();
    in_valid = 1'b1; in_data = 16'(100);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd5; coef_wdata = 16'(999);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    chk("drop_pulse", coef_drop, 1);
    @(posedge CLK); #1;
    chk("drop_clear", coef_drop, 0);
    burst(0);
    chk("drop_old_h5", tc[5], 6);

    // Same-cycle coefficient write and accept: tap 0 uses the new h[0].
    wait_ready();
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'(50);
    in_valid = 1'b1; in_data = 16'(3);
    @(posedge CLK); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    chk("same_coef", mac_coef, 50);
    chk("same_data", mac_in_data, 3);

    // Flush beats in_valid; next burst sees only the new sample.
    wait_ready();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'(9);
    #1;
    chk("flush_ready", in_ready, 0);
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_noburst", mac_input_valid, 0);
    burst(7);
    for (int k = 0; k < N; k++) chk("flush_tap", td[k], k == 0 ? 7 : 0);

    // Reset mid-burst at tap 8.
    wait_ready();
    in_valid = 1'b1; in_data = 16'(11);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge CLK); #1; end
    chk("pre_rst_vld", mac_input_valid, 1);
    chk("pre_rst_data", mac_in_data, 0);
    #2 ARST = 1'b1;
    #1;
    chk("arst_vld", mac_input_valid, 0);
    chk("arst_init", mac_initialize, 0);
    chk("arst_data", mac_in_data, 0);
    chk("arst_coef", mac_coef, 0);
    chk("arst_busy", busy, 0);
    #3 ARST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_vld", mac_input_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    burst(5);
    for (int k = 0; k < N; k++) chk("post_rst_tap", td[k], k == 0 ? 5 : 0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = 16'($urandom);
      coef_we    = ($urandom_range(0, 3) == 0);
      coef_addr  = 4'($urandom_range(0, N - 1));
      coef_wdata = 16'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0; coef_we = 1'b0; flush = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 16, number of filter taps per output sample (fixed power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 16, sample and coefficient width (signed).
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 ARST  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  new input sample offered.
REQ-006 in_ready  output  1  sequencer can accept a sample; combinational: high iff state IDLE and flush low.
REQ-007 in_data  input  DATA_W  signed input sample x[n].
REQ-008 coef_we  input  1  coefficient write strobe.
REQ-009 coef_addr  input  log2(NUM_TAPS)  coefficient index k.
REQ-010 coef_wdata  input  DATA_W  signed coefficient h[k].
REQ-011 coef_drop  output  1  one-cycle pulse: coefficient write rejected.
REQ-012 flush  input  1  clear sample history.
REQ-013 mac_initialize  output  1  first tap of a burst; the MAC restarts its accumulator.
REQ-014 mac_input_valid  output  1  tap operands valid this cycle.
REQ-015 mac_in_data  output  DATA_W  signed delayed sample for the current tap.
REQ-016 mac_coef  output  DATA_W  signed coefficient for the current tap.
REQ-017 busy  output  1  high while state BURST.

Function
REQ-018 The FSM SHALL have two states: IDLE, BURST.
REQ-019 In IDLE, a cycle with in_valid and in_ready high SHALL write in_data into the delay line at wr_ptr, advance wr_ptr modulo NUM_TAPS, clear tap index k to 0, and enter BURST.
REQ-020 In BURST, the sequencer SHALL emit exactly NUM_TAPS consecutive tap cycles, k = 0..NUM_TAPS-1, then return to IDLE; there are no gaps and no stall input.
REQ-021 All mac_* outputs SHALL be registered; tap k=0 SHALL appear the cycle after the accepting edge.
REQ-022 Tap k SHALL present mac_in_data = x[n-k] (n = newest sample) and mac_coef = h[k].
REQ-023 mac_input_valid SHALL be high on all NUM_TAPS tap cycles and low otherwise.
REQ-024 mac_initialize SHALL be high only on tap k=0.
REQ-025 Outside tap cycles, mac_in_data and mac_coef SHALL be 0.
REQ-026 Throughput: one sample per NUM_TAPS+1 cycles; in_ready SHALL be low throughout BURST.
REQ-027 History entries never written since reset or flush SHALL read as 0.
REQ-028 wr_ptr SHALL wrap from NUM_TAPS-1 to 0; the read index (wr_ptr_newest - k) SHALL wrap modulo NUM_TAPS.
REQ-029 A coef_we in IDLE SHALL update h[coef_addr], visible from the next burst.
REQ-030 A coef_we in BURST SHALL be dropped and SHALL pulse coef_drop on the following cycle.
REQ-031 flush in IDLE SHALL zero all delay-line entries and wr_ptr in one cycle; flush in BURST SHALL be ignored.
REQ-032 If flush and in_valid are high in the same IDLE cycle, flush SHALL win and the sample SHALL not be accepted.
REQ-033 A coef_we and an accepted sample in the same IDLE cycle SHALL both take effect; the burst uses the new coefficient.

Reset
REQ-034 ARST SHALL force: state IDLE, k=0, wr_ptr=0, all delay-line entries and coefficients 0, all mac_* outputs 0, coef_drop 0, busy 0.
REQ-035 ARST asserted mid-burst SHALL abort the burst immediately with no further tap cycles; the first accept after release starts a fresh burst.

Structure
REQ-036 Shared package fir_pkg SHALL hold NUM_TAPS, DATA_W, the tap-index width and the FSM state enum.
REQ-037 The circular sample buffer SHALL be a sub-module fir_delay_line (write port, read index, flush).

Verification
REQ-038 Impulse: h[k]=k+1, input samples 1,0,0,... -> burst 1 taps: data 1,0,...,0; burst j: data at k=j only; with an ideal MAC, outputs 1,2,...,16.
REQ-039 Timing: accept at edge E -> mac_initialize=1 at E+1 only; mac_input_valid high E+1..E+16; in_ready high again from E+17.
REQ-040 Wrap: 20 samples 1..20, then an accept of 21 -> taps carry 21,20,...,6.
REQ-041 Coefficient write at k=5 mid-burst -> coef_drop pulses one cycle; the next burst still uses the old h[5].
REQ-042 flush with in_valid in IDLE -> in_ready=0, no burst; the next sample 7 -> taps 7,0,...,0.
REQ-043 ARST at k=8 -> all mac_* outputs 0 the same cycle; the next accept gives history 0 apart from the new sample.
